// File: rtl/seg_merger_pipe.sv
// Two-stage segment merger: places each segment result by its shift, accumulates the
// beats of a group modulo 2^OUT_W and emits one registered result per group.
module seg_merger_pipe #(
    parameter int unsigned SEG_W = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned SH_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [SEG_W-1:0] in_data_i,
    input  logic [SH_W-1:0]  in_shift_i,
    input  logic             in_last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] out_data_o,
    output logic             out_ovf_o,
    output logic             out_rng_o,
    output logic [15:0]      grp_cnt_o
);

    localparam int unsigned MaxShift = OUT_W - SEG_W;
    localparam int unsigned PadW     = OUT_W - SEG_W;

    // Stage 1 registers
    logic             s1_valid_q, s1_valid_d;
    logic [SEG_W-1:0] s1_data_q, s1_data_d;
    logic [SH_W-1:0]  s1_shift_q, s1_shift_d;
    logic             s1_last_q, s1_last_d;

    // Stage 2 group state
    logic [OUT_W-1:0] acc_q, acc_d;
    logic             grp_ovf_q, grp_ovf_d;
    logic             grp_rng_q, grp_rng_d;

    // Output registers
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;
    logic             out_rng_q, out_rng_d;
    logic [15:0]      grp_cnt_q, grp_cnt_d;

    logic             stall;
    logic             s1_fire;
    logic             out_fire;
    logic             beat_rng;
    logic [OUT_W-1:0] aligned;
    logic [OUT_W-1:0] merged;
    logic [OUT_W:0]   sum;

    // Stage 1 may only hold when its last beat has nowhere to go.
    assign stall      = s1_valid_q & s1_last_q & out_valid_q & ~out_ready_i;
    assign in_ready_o = ~stall;
    assign s1_fire    = s1_valid_q & ~stall;
    assign out_fire   = out_valid_q & out_ready_i;

    assign beat_rng = ({{(32 - SH_W){1'b0}}, s1_shift_q} > MaxShift);
    assign aligned  = {s1_data_q, {PadW{1'b0}}};
    assign merged   = beat_rng ? '0 : (aligned >> s1_shift_q);
    assign sum      = {1'b0, acc_q} + {1'b0, merged};

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_shift_d  = s1_shift_q;
        s1_last_d   = s1_last_q;
        acc_d       = acc_q;
        grp_ovf_d   = grp_ovf_q;
        grp_rng_d   = grp_rng_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        out_rng_d   = out_rng_q;
        grp_cnt_d   = grp_cnt_q;

        if (in_ready_o) begin
            s1_valid_d = in_valid_i;
            if (in_valid_i) begin
                s1_data_d  = in_data_i;
                s1_shift_d = in_shift_i;
                s1_last_d  = in_last_i;
            end
        end

        if (out_fire) begin
            out_valid_d = 1'b0;
            grp_cnt_d   = grp_cnt_q + 16'd1;
        end

        if (s1_fire) begin
            if (s1_last_q) begin
                // Close the group: this beat's carry and range flag are included.
                out_valid_d = 1'b1;
                out_data_d  = sum[OUT_W-1:0];
                out_ovf_d   = grp_ovf_q | sum[OUT_W];
                out_rng_d   = grp_rng_q | beat_rng;
                acc_d       = '0;
                grp_ovf_d   = 1'b0;
                grp_rng_d   = 1'b0;
            end else begin
                acc_d     = sum[OUT_W-1:0];
                grp_ovf_d = grp_ovf_q | sum[OUT_W];
                grp_rng_d = grp_rng_q | beat_rng;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_shift_q  <= '0;
            s1_last_q   <= 1'b0;
            acc_q       <= '0;
            grp_ovf_q   <= 1'b0;
            grp_rng_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_rng_q   <= 1'b0;
            grp_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_shift_q  <= s1_shift_d;
            s1_last_q   <= s1_last_d;
            acc_q       <= acc_d;
            grp_ovf_q   <= grp_ovf_d;
            grp_rng_q   <= grp_rng_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_rng_q   <= out_rng_d;
            grp_cnt_q   <= grp_cnt_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_ovf_o   = out_ovf_q;
    assign out_rng_o   = out_rng_q;
    assign grp_cnt_o   = grp_cnt_q;

endmodule

// File: tb/tb_seg_merger_pipe.sv
// Scoreboard bench for seg_merger_pipe: a reference model predicts each group result
// at beat acceptance; a monitor pops and compares on every output transfer.
module tb_seg_merger_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0;
    logic [4:0]  in_shift = 5'h0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_ovf;
    logic        out_rng;
    logic [15:0] grp_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_acc = 32'h0;
    logic        m_ovf = 1'b0;
    logic        m_rng = 1'b0;
    logic [33:0] sb_q[$];
    int          grp_model = 0;
    int          n_accepted = 0;
    int          groups_sent = 0;
    int          ready_mode = 1;

    seg_merger_pipe #(
        .SEG_W(16),
        .OUT_W(32),
        .SH_W (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .in_shift_i (in_shift),
        .in_last_i  (in_last),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .out_ovf_o  (out_ovf),
        .out_rng_o  (out_rng),
        .grp_cnt_o  (grp_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_merge(input logic [15:0] d, input logic [4:0] s);
        logic [31:0] w;
        w = {16'h0, d};
        if (s > 5'd16) return 32'h0;
        return w << (5'd16 - s);
    endfunction

    task automatic model_accept(input logic [15:0] d, input logic [4:0] s, input logic l);
        logic [32:0] sum;
        sum   = {1'b0, m_acc} + {1'b0, ref_merge(d, s)};
        m_ovf = m_ovf | sum[32];
        m_rng = m_rng | (s > 5'd16);
        if (l) begin
            sb_q.push_back({m_ovf, m_rng, sum[31:0]});
            m_acc = 32'h0;
            m_ovf = 1'b0;
            m_rng = 1'b0;
            groups_sent++;
        end else begin
            m_acc = sum[31:0];
        end
    endtask

    task automatic send_beat(input logic [15:0] d, input logic [4:0] s, input logic l);
        int waits;
        waits = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_shift = s;
        in_last  = l;
        #1;
        while (!in_ready && waits < 1000) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (!in_ready) begin
            check_eq("in_ready_timeout", 64'(in_ready), 64'd1);
        end else begin
            @(posedge clk);
            model_accept(d, s, l);
            n_accepted++;
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        in_shift = 5'd0;
        in_last  = 1'b1;
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_data", 64'(out_data), 64'd0);
        check_eq("rst_out_flags", 64'({out_ovf, out_rng}), 64'd0);
        check_eq("rst_grp_cnt", 64'(grp_cnt), 64'd0);
        sb_q.delete();
        m_acc     = 32'h0;
        m_ovf     = 1'b0;
        m_rng     = 1'b0;
        grp_model = 0;
        groups_sent = 0;
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("post_rst_idle", 64'(out_valid), 64'd0);
    endtask

    task automatic drain;
        int w;
        w = 0;
        while ((sb_q.size() != 0 || out_valid) && w < 300) begin
            @(negedge clk);
            w++;
        end
        check_eq("drain_pending", 64'(sb_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            case (ready_mode)
                0: out_ready = 1'b0;
                1: out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    logic        hold = 1'b0;
    logic [33:0] held;
    logic [33:0] exp_res;

    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check_eq("hold_valid", 64'(out_valid), 64'd1);
                    check_eq("hold_result", 64'({out_ovf, out_rng, out_data}), 64'(held));
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        check_eq("unexpected_output", 64'd1, 64'd0);
                    end else begin
                        exp_res = sb_q.pop_front();
                        check_eq("out_data", 64'(out_data), 64'(exp_res[31:0]));
                        check_eq("out_ovf", 64'(out_ovf), 64'(exp_res[33]));
                        check_eq("out_rng", 64'(out_rng), 64'(exp_res[32]));
                    end
                    grp_model++;
                end
                hold = out_valid && !out_ready;
                held = {out_ovf, out_rng, out_data};
            end
        end
    end

    initial begin
        int len;
        logic [15:0] d;
        do_reset();

        // Single beat and two-cycle latency
        send_beat(16'hABCD, 5'd0, 1'b1);
        check_eq("latency_n1_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check_eq("latency_n2_valid", 64'(out_valid), 64'd1);
        check_eq("abcd_data", 64'(out_data), 64'h0000_0000_ABCD_0000);
        drain();

        // Range boundary
        send_beat(16'h1234, 5'd16, 1'b1);
        send_beat(16'h1234, 5'd17, 1'b1);
        drain();

        // Accumulator wrap then a clean group
        send_beat(16'h8000, 5'd0, 1'b0);
        send_beat(16'h8000, 5'd0, 1'b1);
        send_beat(16'h0001, 5'd16, 1'b1);
        drain();

        // Backpressure: two accepted, then held
        do_reset();
        ready_mode = 0;
        repeat (2) @(negedge clk);
        n_accepted = 0;
        send_beat(16'h1001, 5'd16, 1'b1);
        send_beat(16'h1002, 5'd16, 1'b1);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h1003;
        in_shift = 5'd16;
        in_last  = 1'b1;
        repeat (4) begin
            #1;
            check_eq("bp_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        check_eq("bp_accepted", 64'(n_accepted), 64'd2);
        check_eq("bp_out_valid", 64'(out_valid), 64'd1);
        check_eq("bp_out_data", 64'(out_data), 64'h0000_0000_0000_1001);
        in_valid   = 1'b0;
        ready_mode = 1;
        send_beat(16'h1003, 5'd16, 1'b1);
        send_beat(16'h1004, 5'd16, 1'b1);
        send_beat(16'h1005, 5'd16, 1'b1);
        drain();
        check_eq("bp_grp_cnt", 64'(grp_cnt), 64'd5);

        // Reset in the middle of a group
        send_beat(16'h0001, 5'd0, 1'b0);
        do_reset();
        send_beat(16'h0001, 5'd16, 1'b1);
        drain();
        check_eq("mid_rst_data_cnt", 64'(grp_cnt), 64'd1);

        // Random groups under random backpressure
        ready_mode = 2;
        for (int g = 0; g < 60; g++) begin
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                d = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
                send_beat(d, 5'($urandom_range(0, 18)), b == len - 1);
            end
        end
        ready_mode = 1;
        drain();
        check_eq("rand_grp_cnt", 64'(grp_cnt), 64'(groups_sent));
        check_eq("rand_transfers", 64'(grp_model), 64'(groups_sent));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_merger_pipe.md
SEG_MERGER_PIPE -- requirements
Module: seg_merger_pipe

Interface
REQ-001 Parameter SEG_W, default 16: width of the incoming segment result.
REQ-002 Parameter OUT_W, default 32: width of the merged output and accumulator; OUT_W > SEG_W.
REQ-003 Parameter SH_W, default 5: width of the shift (discarded-bit count) input.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  input beat valid.
REQ-007 in_ready  output  1  block accepts beat this cycle.
REQ-008 in_data  input  SEG_W  segment result.
REQ-009 in_shift  input  SH_W  number of discarded leading bits (segment position).
REQ-010 in_last  input  1  final beat of an accumulation group.
REQ-011 out_valid  output  1  merged group result valid.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_data  output  OUT_W  merged/accumulated result.
REQ-014 out_ovf  output  1  accumulator wrapped within the group.
REQ-015 out_rng  output  1  at least one beat of the group had an out-of-range shift.
REQ-016 grp_cnt  output  16  count of groups delivered (out_valid & out_ready), wraps at 2^16.

Function
REQ-017 Beat transfers when in_valid & in_ready; result transfers when out_valid & out_ready.
REQ-018 Merged value per beat: in_data placed with in_shift zeros above it and OUT_W-SEG_W-in_shift zeros below (left-aligned then shifted right by in_shift).
REQ-019 in_shift > OUT_W-SEG_W: merged value = 0, group out_rng flag set.
REQ-020 Stage 1 registers in_data, in_shift, in_last (s1_valid).
REQ-021 Stage 2 adds merged value to OUT_W accumulator, modulo 2^OUT_W; carry-out sets group out_ovf flag.
REQ-022 Non-last beat: accumulator and flags update, no output produced.
REQ-023 Last beat: output register loads acc+merged and the group flags (including this beat's), out_valid=1; accumulator and group flags clear to 0 in the same cycle.
REQ-024 Single-beat group (in_last=1 on every beat) is a plain registered merge.
REQ-025 Latency: last beat accepted in cycle N -> out_valid in cycle N+2 absent backpressure.
REQ-026 Stage 1 advances unless it holds a last beat while out_valid=1 and out_ready=0.
REQ-027 in_ready = !s1_valid | !s1_last | !out_valid | out_ready (combinational, no dependency on in_valid).
REQ-028 Throughput one beat per cycle when out_ready=1.
REQ-029 out_data, out_ovf, out_rng stable while out_valid=1 and out_ready=0.
REQ-030 out_valid clears on transfer unless a new last beat loads the same cycle, in which case it stays 1 with new data.
REQ-031 Groups emerge in acceptance order; no beat dropped or duplicated under any backpressure pattern.
REQ-032 grp_cnt increments by 1 on each result transfer; 0xFFFF wraps to 0x0000.

Reset
REQ-033 rst=1 immediately clears s1_valid, accumulator, group flags, out_valid, out_data, out_ovf, out_rng, grp_cnt to 0.
REQ-034 Reset mid-group discards the partial group; first beat after reset starts a new group.
REQ-035 During rst=1, in_ready = 1 (pipeline empty) but no beat is captured.

Verification
REQ-036 Single beat 0xABCD, shift 0, last -> two cycles later out_data=0xABCD0000, ovf=0, rng=0.
REQ-037 Beat 0x1234 shift 16 last -> 0x00001234; beat 0x1234 shift 17 last -> out_data=0x00000000, out_rng=1.
REQ-038 Group 0x8000/shift 0 then 0x8000/shift 0 last -> out_data=0x00000000, out_ovf=1; next group 0x0001/shift 16 last -> 0x00000001, ovf=0.
REQ-039 out_ready=0, five single-beat groups offered back-to-back -> two accepted then in_ready=0, out_data held at first result; release out_ready -> all five delivered in order, grp_cnt=5.
REQ-040 rst pulse after first beat of a two-beat group -> all outputs 0; then 0x0001/shift 16 last -> out_data=0x00000001, grp_cnt=1.
